// File: rtl/mem_burst_pkg.sv
// Shared types and helpers for the cache-line burst controller.
// Beat-width helpers take the beat count so that any legal BEATS parameter can use them.
package mem_burst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        LAST = 2'd3
    } state_e;

    localparam int DEFAULT_BEATS = 4;

    function automatic int beat_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic int last_beat(input int beats);
        return beats - 1;
    endfunction

    localparam int BEAT_W    = beat_w(DEFAULT_BEATS);
    localparam int LAST_BEAT = last_beat(DEFAULT_BEATS);

endpackage

// File: rtl/spram1.sv
// Single-port RAM with byte enables and a one-cycle registered read.
// A read issued in cycle N appears on out in cycle N+1 (read-first on a same-address write).
module spram1 #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 128
) (
    input  logic                  clk,
    input  logic [AWIDTH-1:0]     address,
    input  logic                  wren,
    input  logic [DWIDTH/8-1:0]   byteen,
    input  logic [DWIDTH-1:0]     data,
    output logic [DWIDTH-1:0]     out
);

    logic [DWIDTH-1:0] mem_array [2**AWIDTH];
    logic [DWIDTH-1:0] out_q;

    always_ff @(posedge clk) begin
        if (wren) begin
            for (int b = 0; b < DWIDTH/8; b++) begin
                if (byteen[b]) begin
                    mem_array[address][b*8 +: 8] <= data[b*8 +: 8];
                end
            end
        end
        out_q <= mem_array[address];
    end

    assign out = out_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Line-miss burst controller: optional victim writeback, then a pipelined line fill
// that streams beats back to the cache one cycle behind each RAM read issue.
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 128,
    parameter int BEATS  = 4,
    parameter int LWIDTH = AWIDTH - $clog2(BEATS)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_dirty,
    input  logic [LWIDTH-1:0]           req_wb_line,
    input  logic [LWIDTH-1:0]           req_fill_line,
    output logic [$clog2(BEATS)-1:0]    wb_idx,
    input  logic [DWIDTH-1:0]           wb_data,
    output logic                        fill_valid,
    output logic [$clog2(BEATS)-1:0]    fill_idx,
    output logic [DWIDTH-1:0]           fill_data,
    output logic                        done,
    output logic [AWIDTH-1:0]           mem_address,
    output logic                        mem_wren,
    output logic [DWIDTH/8-1:0]         mem_byteen,
    output logic [DWIDTH-1:0]           mem_data,
    input  logic [DWIDTH-1:0]           mem_out
);

    localparam int BW = beat_w(BEATS);
    localparam logic [BW-1:0] LAST_CNT = BW'(last_beat(BEATS));

    state_e              state_q, state_d;
    logic [BW-1:0]       cnt_q, cnt_d;
    logic                dirty_q, dirty_d;
    logic [LWIDTH-1:0]   wb_line_q, wb_line_d;
    logic [LWIDTH-1:0]   fill_line_q, fill_line_d;
    logic                issue_v_q, issue_v_d;
    logic [BW-1:0]       issue_idx_q, issue_idx_d;
    logic                done_q, done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dirty_d     = dirty_q;
        wb_line_d   = wb_line_q;
        fill_line_d = fill_line_q;
        done_d      = 1'b0;
        // Remember which beat was issued this cycle; its data arrives next cycle.
        issue_v_d   = (state_q == FILL);
        issue_idx_d = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    dirty_d     = req_dirty;
                    wb_line_d   = req_wb_line;
                    fill_line_d = req_fill_line;
                    cnt_d       = '0;
                    state_d     = req_dirty ? WB : FILL;
                end
            end
            WB: begin
                cnt_d = cnt_q + BW'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                cnt_d = cnt_q + BW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = LAST;
                    done_d  = 1'b1;
                end
            end
            LAST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dirty_q     <= 1'b0;
            wb_line_q   <= '0;
            fill_line_q <= '0;
            issue_v_q   <= 1'b0;
            issue_idx_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dirty_q     <= dirty_d;
            wb_line_q   <= wb_line_d;
            fill_line_q <= fill_line_d;
            issue_v_q   <= issue_v_d;
            issue_idx_q <= issue_idx_d;
            done_q      <= done_d;
        end
    end

    // RAM port is decoded from registered state only; req_* never reaches it directly.
    always_comb begin
        mem_wren    = 1'b0;
        mem_byteen  = '0;
        mem_data    = '0;
        mem_address = '0;
        wb_idx      = '0;
        case (state_q)
            WB: begin
                mem_wren    = 1'b1;
                mem_byteen  = '1;
                mem_data    = wb_data;
                mem_address = {wb_line_q, cnt_q};
                wb_idx      = cnt_q;
            end
            FILL: begin
                mem_address = {fill_line_q, cnt_q};
            end
            default: begin
            end
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign fill_valid = issue_v_q;
    assign fill_idx   = issue_idx_q;
    assign fill_data  = mem_out;
    assign done       = done_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with spram1 behind it; the bench can borrow
// the RAM port while the controller is idle to preload and inspect memory.
module tb_mem_burst_ctrl;

    logic         clk;
    logic         resetn;
    logic         req_valid;
    logic         req_ready;
    logic         req_dirty;
    logic [7:0]   req_wb_line;
    logic [7:0]   req_fill_line;
    logic [1:0]   wb_idx;
    logic [127:0] wb_data;
    logic         fill_valid;
    logic [1:0]   fill_idx;
    logic [127:0] fill_data;
    logic         done;
    logic [9:0]   mem_address;
    logic         mem_wren;
    logic [15:0]  mem_byteen;
    logic [127:0] mem_data;
    logic [127:0] mem_out;

    logic         tb_own;
    logic [9:0]   tb_addr;
    logic         tb_wren;
    logic [127:0] tb_data;
    logic [9:0]   ram_address;
    logic         ram_wren;
    logic [15:0]  ram_byteen;
    logic [127:0] ram_data;

    logic [127:0] wb_src [4];

    int n_pass;
    int n_fail;
    int n_total;

    assign ram_address = tb_own ? tb_addr : mem_address;
    assign ram_wren    = tb_own ? tb_wren : mem_wren;
    assign ram_byteen  = tb_own ? 16'hFFFF : mem_byteen;
    assign ram_data    = tb_own ? tb_data : mem_data;
    assign wb_data     = wb_src[wb_idx];

    mem_burst_ctrl #(.AWIDTH(10), .DWIDTH(128), .BEATS(4)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_dirty(req_dirty),
        .req_wb_line(req_wb_line), .req_fill_line(req_fill_line),
        .wb_idx(wb_idx), .wb_data(wb_data),
        .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
        .done(done),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_byteen(mem_byteen),
        .mem_data(mem_data), .mem_out(mem_out)
    );

    spram1 #(.AWIDTH(10), .DWIDTH(128)) ram (
        .clk(clk), .address(ram_address), .wren(ram_wren), .byteen(ram_byteen),
        .data(ram_data), .out(mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pat(input logic [7:0] tag, input int k);
        return {4{tag, 8'(k), 16'h5A00 + 16'(k)}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ram_write(input logic [9:0] a, input logic [127:0] d);
        tb_addr = a;
        tb_data = d;
        tb_wren = 1'b1;
        @(negedge clk);
        tb_wren = 1'b0;
    endtask

    task automatic ram_read(input logic [9:0] a, output logic [127:0] d);
        tb_addr = a;
        tb_wren = 1'b0;
        @(negedge clk);
        d = mem_out;
    endtask

    task automatic send(input logic dirty, input logic [7:0] wbl, input logic [7:0] fl);
        req_valid     = 1'b1;
        req_dirty     = dirty;
        req_wb_line   = wbl;
        req_fill_line = fl;
    endtask

    initial begin
        logic [127:0] rd;
        n_pass = 0; n_fail = 0; n_total = 0;
        resetn = 1'b0; req_valid = 1'b0; req_dirty = 1'b0;
        req_wb_line = '0; req_fill_line = '0;
        tb_own = 1'b1; tb_addr = '0; tb_wren = 1'b0; tb_data = '0;
        for (int k = 0; k < 4; k++) wb_src[k] = '0;

        repeat (3) @(negedge clk);
        chk("rst.req_ready",  128'(req_ready),  128'(1));
        chk("rst.done",       128'(done),       128'(0));
        chk("rst.fill_valid", 128'(fill_valid), 128'(0));
        chk("rst.fill_idx",   128'(fill_idx),   128'(0));
        chk("rst.wb_idx",     128'(wb_idx),     128'(0));
        chk("rst.mem_wren",   128'(mem_wren),   128'(0));
        chk("rst.mem_addr",   128'(mem_address), 128'(0));
        chk("rst.mem_byteen", 128'(mem_byteen), 128'(0));
        chk("rst.mem_data",   mem_data,         128'(0));
        resetn = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            ram_write(10'h040 + 10'(k), pat(8'hA0, k));
            ram_write(10'h014 + 10'(k), pat(8'hC0, k));
            ram_write(10'h3FC + 10'(k), pat(8'hF0, k));
        end
        ram_write(10'h000, pat(8'h99, 0));

        // Clean fill of line 0x10.
        tb_own = 1'b0;
        send(1'b0, 8'h00, 8'h10);
        chk("t1.ready_c0", 128'(req_ready), 128'(1));
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            chk($sformatf("t1.ready c%0d", c), 128'(req_ready), 128'(c == 6));
            chk($sformatf("t1.done c%0d", c), 128'(done), 128'(c == 5));
            chk($sformatf("t1.wren c%0d", c), 128'(mem_wren), 128'(0));
            if (c <= 4) chk($sformatf("t1.addr c%0d", c), 128'(mem_address), 128'(10'h040 + 10'(c - 1)));
            chk($sformatf("t1.fvalid c%0d", c), 128'(fill_valid), 128'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) begin
                chk($sformatf("t1.fidx c%0d", c), 128'(fill_idx), 128'(c - 2));
                chk($sformatf("t1.fdata c%0d", c), fill_data, pat(8'hA0, c - 2));
            end
        end

        // Dirty writeback of line 0x03, then fill of line 0x05.
        for (int k = 0; k < 4; k++) wb_src[k] = pat(8'hB0, k);
        send(1'b1, 8'h03, 8'h05);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            chk($sformatf("t2.ready c%0d", c), 128'(req_ready), 128'(c == 10));
            chk($sformatf("t2.done c%0d", c), 128'(done), 128'(c == 9));
            chk($sformatf("t2.wren c%0d", c), 128'(mem_wren), 128'(c <= 4));
            if (c <= 4) begin
                chk($sformatf("t2.waddr c%0d", c), 128'(mem_address), 128'(10'h00C + 10'(c - 1)));
                chk($sformatf("t2.byteen c%0d", c), 128'(mem_byteen), 128'(16'hFFFF));
                chk($sformatf("t2.wdata c%0d", c), mem_data, pat(8'hB0, c - 1));
                chk($sformatf("t2.wbidx c%0d", c), 128'(wb_idx), 128'(c - 1));
            end else begin
                chk($sformatf("t2.byteen c%0d", c), 128'(mem_byteen), 128'(0));
            end
            if (c >= 5 && c <= 8) chk($sformatf("t2.raddr c%0d", c), 128'(mem_address), 128'(10'h014 + 10'(c - 5)));
            chk($sformatf("t2.fvalid c%0d", c), 128'(fill_valid), 128'(c >= 6 && c <= 9));
            if (c >= 6 && c <= 9) begin
                chk($sformatf("t2.fidx c%0d", c), 128'(fill_idx), 128'(c - 6));
                chk($sformatf("t2.fdata c%0d", c), fill_data, pat(8'hC0, c - 6));
            end
        end
        tb_own = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ram_read(10'h00C + 10'(k), rd);
            chk($sformatf("t2.ram %0d", k), rd, pat(8'hB0, k));
        end

        // Back-to-back: request held; second accepted only in the IDLE cycle after done.
        tb_own = 1'b0;
        send(1'b0, 8'h00, 8'h10);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) req_fill_line = 8'h05;
            chk($sformatf("t3.ready c%0d", c), 128'(req_ready), 128'(c == 6 || c == 12));
            chk($sformatf("t3.done c%0d", c), 128'(done), 128'(c == 5 || c == 11));
            if (c == 1) chk("t3.addr c1", 128'(mem_address), 128'(10'h040));
            if (c == 7) begin
                chk("t3.addr c7", 128'(mem_address), 128'(10'h014));
                req_valid = 1'b0;
            end
            if (c == 5)  chk("t3.fdata c5", fill_data, pat(8'hA0, 3));
            if (c == 11) chk("t3.fdata c11", fill_data, pat(8'hC0, 3));
        end

        // Reset in the middle of a writeback.
        tb_own = 1'b1;
        for (int k = 0; k < 4; k++) ram_write(10'h00C + 10'(k), pat(8'hD0, k));
        for (int k = 0; k < 4; k++) wb_src[k] = pat(8'hE0, k);
        tb_own = 1'b0;
        send(1'b1, 8'h03, 8'h05);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (c <= 2) begin
                chk($sformatf("t4.wren c%0d", c), 128'(mem_wren), 128'(1));
                chk($sformatf("t4.addr c%0d", c), 128'(mem_address), 128'(10'h00C + 10'(c - 1)));
            end else begin
                chk($sformatf("t4.wren c%0d", c), 128'(mem_wren), 128'(0));
                chk($sformatf("t4.fvalid c%0d", c), 128'(fill_valid), 128'(0));
                chk($sformatf("t4.ready c%0d", c), 128'(req_ready), 128'(1));
                chk($sformatf("t4.addr c%0d", c), 128'(mem_address), 128'(0));
            end
            if (c == 2) resetn = 1'b0;
            if (c == 3) resetn = 1'b1;
        end
        tb_own = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ram_read(10'h00C + 10'(k), rd);
            chk($sformatf("t4.ram %0d", k), rd, (k < 2) ? pat(8'hE0, k) : pat(8'hD0, k));
        end

        // Top line: addresses stay inside line 0xFF.
        tb_own = 1'b0;
        send(1'b0, 8'h00, 8'hFF);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            chk($sformatf("t5.addr c%0d", c), 128'(mem_address),
                128'((c <= 4) ? (10'h3FC + 10'(c - 1)) : 10'h000));
            if (c >= 2 && c <= 5) chk($sformatf("t5.fdata c%0d", c), fill_data, pat(8'hF0, c - 2));
            chk($sformatf("t5.done c%0d", c), 128'(done), 128'(c == 5));
        end
        tb_own = 1'b1;
        ram_read(10'h000, rd);
        chk("t5.ram0", rd, pat(8'h99, 0));

        // Writeback and fill of the same line returns the freshly written beats.
        tb_own = 1'b0;
        for (int k = 0; k < 4; k++) wb_src[k] = pat(8'h70, k);
        send(1'b1, 8'h07, 8'h07);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            chk($sformatf("t6.fvalid c%0d", c), 128'(fill_valid), 128'(c >= 6 && c <= 9));
            if (c >= 6 && c <= 9) begin
                chk($sformatf("t6.fidx c%0d", c), 128'(fill_idx), 128'(c - 6));
                chk($sformatf("t6.fdata c%0d", c), fill_data, pat(8'h70, c - 6));
            end
            chk($sformatf("t6.done c%0d", c), 128'(done), 128'(c == 9));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
